// File: rtl/fetch_unit.sv
// IF-stage fetch engine: owns the PC and addresses a 1-cycle sync imem. A word is presented with exec one cycle after its address.
// Redirects win over stall and squash the in-flight word; stall re-reads the current word; a HALT opcode stops fetch until redirect or rst.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] inst,
  output logic [15:0] pc_plus1,
  output logic        exec,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] pc_d, pc_d_nxt;
  logic        vld_d, vld_d_nxt;
  logic        halt_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pc_d        <= RESET_PC;
      vld_d       <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      pc_d  <= pc_d_nxt;
      vld_d <= vld_d_nxt;
      if (exec && !stall)
        fetch_count <= fetch_count + 16'd1;
    end
  end

  assign inst     = imem_rdata;
  assign pc_plus1 = pc_d + 16'd1;
  assign exec     = vld_d && (state == RUN) && !redirect_valid && !rst;
  assign halted   = (state == HALT) && !rst;
  assign halt_hit = exec && !stall && (imem_rdata[15:12] == HALT_OP);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pc_d_nxt  = pc_d;
    vld_d_nxt = vld_d;
    imem_addr = pc_d;

    if (rst) begin
      imem_addr = RESET_PC;
    end else if (redirect_valid) begin
      // Any state: the word on imem_rdata is wrong-path, restart at the target.
      imem_addr = redirect_pc;
      pc_nxt    = redirect_pc + 16'd1;
      pc_d_nxt  = redirect_pc;
      vld_d_nxt = 1'b1;
      state_nxt = RUN;
    end else begin
      case (state)
        BOOT: begin
          imem_addr = pc;
          pc_nxt    = pc + 16'd1;
          pc_d_nxt  = pc;
          vld_d_nxt = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          if (stall) begin
            imem_addr = pc_d;
          end else if (halt_hit) begin
            imem_addr = pc_d;
            state_nxt = HALT;
          end else begin
            imem_addr = pc;
            pc_nxt    = pc + 16'd1;
            pc_d_nxt  = pc;
            vld_d_nxt = 1'b1;
          end
        end
        HALT: begin
          imem_addr = pc_d;
        end
        default: begin
          imem_addr = pc_d;
          state_nxt = BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of expected delivered words plus directed checks on stall, redirect, HALT, wrap and reset.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc1;
  } sb_t;

  logic        clk;
  logic        rst, stall, redirect_valid;
  logic [15:0] redirect_pc, imem_addr, imem_rdata, inst, pc_plus1, fetch_count;
  logic        exec, halted;

  logic        rst2, stall2, redirect_valid2;
  logic [15:0] redirect_pc2, imem_addr2, imem_rdata2, inst2, pc_plus1_2, fetch_count2;
  logic        exec2, halted2;

  int  n_err = 0;
  int  n_chk = 0;
  sb_t sb[$];
  sb_t mon_e;

  fetch_unit #(.RESET_PC(16'h0000), .HALT_OP(4'hF)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst(inst), .pc_plus1(pc_plus1), .exec(exec), .halted(halted),
    .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(16'hFFFF), .HALT_OP(4'hF)) u_dut_wrap (
    .clk(clk), .rst(rst2), .stall(stall2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .inst(inst2), .pc_plus1(pc_plus1_2), .exec(exec2), .halted(halted2),
    .fetch_count(fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0007) ? 16'hF000 : 16'h1000 + a;
  endfunction

  always @(posedge clk) begin
    imem_rdata  <= mem_word(imem_addr);
    imem_rdata2 <= mem_word(imem_addr2);
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] a);
    sb_t e;
    e.inst = mem_word(a);
    e.pc1  = a + 16'd1;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every non-stalled exec word must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && exec && !stall) begin
      if (sb.size() == 0) begin
        check("sb_extra_word_exec", {15'd0, exec}, 16'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_inst", inst, mon_e.inst);
        check("sb_pc_plus1", pc_plus1, mon_e.pc1);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'd0;
    rst2 = 1'b1; stall2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = 16'd0;
    for (int i = 0; i <= 6; i++) push(16'(i));

    cyc(); cyc();
    @(negedge clk);
    check("rst_exec", {15'd0, exec}, 16'd0);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_count", fetch_count, 16'd0);

    cyc(); rst = 1'b0;
    @(negedge clk);
    check("boot_exec", {15'd0, exec}, 16'd0);
    check("boot_addr", imem_addr, 16'h0000);

    repeat (6) cyc();
    stall = 1'b1;
    @(negedge clk);
    check("stall_exec", {15'd0, exec}, 16'd1);
    check("stall_addr", imem_addr, 16'h0005);
    check("stall_inst", inst, 16'h1005);
    check("stall_pc_plus1", pc_plus1, 16'h0006);
    check("stall_count", fetch_count, 16'd5);
    for (int j = 0; j < 2; j++) begin
      cyc();
      @(negedge clk);
      check("stall_hold_addr", imem_addr, 16'h0005);
      check("stall_hold_inst", inst, 16'h1005);
      check("stall_hold_count", fetch_count, 16'd5);
    end
    cyc(); stall = 1'b0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    check("release_inst", inst, 16'h1006);
    check("release_count", fetch_count, 16'd6);

    cyc(); redirect_valid = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    push(16'h0040); push(16'h0041);
    @(negedge clk);
    check("redir_exec", {15'd0, exec}, 16'd0);
    check("redir_addr", imem_addr, 16'h0040);
    cyc(); redirect_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("redir_tgt_exec", {15'd0, exec}, 16'd1);
    check("redir_tgt_inst", inst, 16'h1040);
    check("redir_tgt_pc_plus1", pc_plus1, 16'h0041);
    cyc();

    cyc(); redirect_valid = 1'b1; redirect_pc = 16'h0006;
    push(16'h0006); push(16'h0007);
    @(negedge clk);
    check("redir2_exec", {15'd0, exec}, 16'd0);
    cyc(); redirect_valid = 1'b0;
    cyc();
    @(negedge clk);
    check("halt_word_exec", {15'd0, exec}, 16'd1);
    check("halt_word_inst", inst, 16'hF000);
    check("halt_word_addr", imem_addr, 16'h0007);
    for (int j = 0; j < 3; j++) begin
      cyc();
      @(negedge clk);
      check("halt_halted", {15'd0, halted}, 16'd1);
      check("halt_exec", {15'd0, exec}, 16'd0);
      check("halt_addr", imem_addr, 16'h0007);
    end
    check("halt_count", fetch_count, 16'd11);

    cyc(); redirect_valid = 1'b1; redirect_pc = 16'h0010;
    push(16'h0010); push(16'h0011);
    @(negedge clk);
    check("unhalt_exec", {15'd0, exec}, 16'd0);
    check("unhalt_addr", imem_addr, 16'h0010);
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    check("unhalt_halted", {15'd0, halted}, 16'd0);
    check("unhalt_inst", inst, 16'h1010);
    cyc();

    cyc(); rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0080;
    @(negedge clk);
    check("midrst_exec", {15'd0, exec}, 16'd0);
    check("midrst_halted", {15'd0, halted}, 16'd0);
    check("midrst_addr", imem_addr, 16'h0000);
    check("midrst_count_before", fetch_count, 16'd13);
    cyc();
    @(negedge clk);
    check("midrst_count", fetch_count, 16'd0);
    check("midrst_addr_held", imem_addr, 16'h0000);
    cyc(); rst = 1'b0; redirect_valid = 1'b0;
    push(16'h0000); push(16'h0001); push(16'h0002);
    @(negedge clk);
    check("reboot_exec", {15'd0, exec}, 16'd0);
    check("reboot_addr", imem_addr, 16'h0000);
    cyc(); cyc();
    cyc();
    @(negedge clk);
    check("reboot_count", fetch_count, 16'd2);
    cyc(); rst = 1'b1;

    cyc(); rst2 = 1'b0;
    @(negedge clk);
    check("wrap_boot_addr", imem_addr2, 16'hFFFF);
    check("wrap_boot_exec", {15'd0, exec2}, 16'd0);
    cyc();
    @(negedge clk);
    check("wrap_exec", {15'd0, exec2}, 16'd1);
    check("wrap_inst", inst2, 16'h0FFF);
    check("wrap_pc_plus1", pc_plus1_2, 16'h0000);
    check("wrap_next_addr", imem_addr2, 16'h0000);
    cyc();
    @(negedge clk);
    check("wrap_next_inst", inst2, 16'h1000);
    check("wrap_count", fetch_count2, 16'd1);

    check("sb_leftover", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
